// File: rtl/pic_ack_sequencer.sv
// Purpose : PIC acknowledge sequencer - owns ISR and rotation pointer, raises INT, runs the two-pulse INTA cycle, executes EOI/rotate commands.
// Latency : int_out 1 cycle after a nonzero winner; ISR set / clear_irr on the first INTA fall edge; vector driven on the second.
// Backpressure: none - the CPU paces the sequence through inta_n; EOI strobes are always accepted. Optional macro PIC_AUTO_EOI_EN adds auto-EOI.
module pic_ack_sequencer #(
   parameter int         NUM_IR         = 8,
   parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_IR-1:0] interrupt_from_priorty_resolver,
   input  logic              inta_n,
   input  logic [4:0]        vector_base,
   input  logic              eoi_valid,
   input  logic [2:0]        eoi_type,
   input  logic [2:0]        eoi_level,
`ifdef PIC_AUTO_EOI_EN
   input  logic              aeoi_mode,
   input  logic              rotate_aeoi,
`endif
   output logic              int_out,
   output logic [NUM_IR-1:0] in_service_register,
   output logic [2:0]        rotate,
   output logic [NUM_IR-1:0] clear_irr,
   output logic [7:0]        data_out,
   output logic              data_oe
);

   // Acknowledge sequencer states
   localparam logic [1:0] S_IDLE = 2'd0;  // waiting for a winner
   localparam logic [1:0] S_PEND = 2'd1;  // INT raised, waiting for first INTA
   localparam logic [1:0] S_ACK1 = 2'd2;  // level latched, waiting for second INTA
   localparam logic [1:0] S_ACK2 = 2'd3;  // vector on the bus until INTA rises

   // EOI command encodings {R,SL,EOI}
   localparam logic [2:0] CMD_NS_EOI     = 3'b001;
   localparam logic [2:0] CMD_S_EOI      = 3'b011;
   localparam logic [2:0] CMD_ROT_NS_EOI = 3'b101;
   localparam logic [2:0] CMD_ROT_S_EOI  = 3'b111;
   localparam logic [2:0] CMD_SET_PRI    = 3'b110;

   logic [1:0]        r_state;
   logic              r_int;
   logic [NUM_IR-1:0] r_isr;
   logic [2:0]        r_rotate;
   logic [NUM_IR-1:0] r_clear_irr;
   logic [7:0]        r_data;
   logic              r_data_oe;
   logic              r_inta_prev;
   logic [2:0]        r_level;
`ifdef PIC_AUTO_EOI_EN
   logic              r_spurious;
`endif

   logic              w_fall;
   logic              w_rise;
   logic              w_win_any;
   logic [2:0]        w_win_level;
   logic              w_ns_found;
   logic [2:0]        w_ns_level;
   logic              w_cmd_ns;
   logic              w_cmd_sp;
   logic              w_cmd_rot;
   logic              w_cmd_setpri;
   logic              w_ack_take;
   logic              w_ack_done;
   logic [NUM_IR-1:0] w_isr_set;
   logic [NUM_IR-1:0] w_isr_clr;
   logic [NUM_IR-1:0] w_isr_nxt;
   logic [2:0]        w_rotate_nxt;

   // INTA edges relative to the previous-cycle sample of inta_n
   assign w_fall = r_inta_prev & ~inta_n;
   assign w_rise = ~r_inta_prev & inta_n;

   assign w_win_any = |interrupt_from_priorty_resolver;

   // One-hot winner to level index; the resolver guarantees at most one bit
   always_comb begin
      w_win_level = 3'd0;
      for (int i = 0; i < NUM_IR; i++) begin
         if (interrupt_from_priorty_resolver[i]) begin
            w_win_level = 3'(i);
         end
      end
   end

   // Highest-priority in-service level: scan rotate+1, rotate+2, ... using the pre-update ISR
   always_comb begin
      logic [2:0] idx;
      w_ns_found = 1'b0;
      w_ns_level = 3'd0;
      idx        = 3'd0;
      for (int k = 1; k <= NUM_IR; k++) begin
         idx = r_rotate + 3'(k);
         if (!w_ns_found && r_isr[idx]) begin
            w_ns_found = 1'b1;
            w_ns_level = idx;
         end
      end
   end

   // Command decode: non-specific, specific, rotate flag and set-priority
   assign w_cmd_ns     = eoi_valid && ((eoi_type == CMD_NS_EOI) || (eoi_type == CMD_ROT_NS_EOI));
   assign w_cmd_sp     = eoi_valid && ((eoi_type == CMD_S_EOI)  || (eoi_type == CMD_ROT_S_EOI));
   assign w_cmd_rot    = eoi_type[2];
   assign w_cmd_setpri = eoi_valid && (eoi_type == CMD_SET_PRI);

   // First INTA fall with a live winner records the level; ACK2 rise ends the cycle
   assign w_ack_take = (r_state == S_PEND) && w_fall && w_win_any;
   assign w_ack_done = (r_state == S_ACK2) && w_rise;

   // ISR set and clear masks; set is OR'ed last so it wins over a same-bit clear
   always_comb begin
      w_isr_set = '0;
      w_isr_clr = '0;
      if (w_ack_take) begin
         w_isr_set[w_win_level] = 1'b1;
      end
      if (w_cmd_ns && w_ns_found) begin
         w_isr_clr[w_ns_level] = 1'b1;
      end
      if (w_cmd_sp) begin
         w_isr_clr[eoi_level] = 1'b1;
      end
`ifdef PIC_AUTO_EOI_EN
      if (w_ack_done && aeoi_mode && !r_spurious) begin
         w_isr_clr[r_level] = 1'b1;
      end
`endif
      w_isr_nxt = (r_isr & ~w_isr_clr) | w_isr_set;
   end

   // Next rotation pointer: rotate-on-EOI variants, set priority, then auto-EOI rotation
   always_comb begin
      w_rotate_nxt = r_rotate;
      if (w_cmd_ns && w_cmd_rot && w_ns_found) begin
         w_rotate_nxt = w_ns_level;
      end
      if (w_cmd_sp && w_cmd_rot) begin
         w_rotate_nxt = eoi_level;
      end
      if (w_cmd_setpri) begin
         w_rotate_nxt = eoi_level;
      end
`ifdef PIC_AUTO_EOI_EN
      if (w_ack_done && aeoi_mode && rotate_aeoi && !r_spurious) begin
         w_rotate_nxt = r_level;
      end
`endif
   end

   // ISR and rotation pointer registers; EOI commands act in every FSM state
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_isr    <= '0;
         r_rotate <= 3'b111;
      end else begin
         r_isr    <= w_isr_nxt;
         r_rotate <= w_rotate_nxt;
      end
   end

   // Acknowledge FSM, INT output, IRR clear pulse and vector drive
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_int       <= 1'b0;
         r_clear_irr <= '0;
         r_data      <= 8'd0;
         r_data_oe   <= 1'b0;
         r_inta_prev <= 1'b1;
         r_level     <= 3'd0;
`ifdef PIC_AUTO_EOI_EN
         r_spurious  <= 1'b0;
`endif
      end else begin
         r_inta_prev <= inta_n;
         r_clear_irr <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_win_any) begin
                  r_int   <= 1'b1;
                  r_state <= S_PEND;
               end
            end
            S_PEND: begin
               if (w_fall) begin
                  // A winner gone by the first INTA is reported as spurious
                  r_int   <= 1'b0;
                  r_state <= S_ACK1;
                  if (w_win_any) begin
                     r_level                  <= w_win_level;
                     r_clear_irr[w_win_level] <= 1'b1;
                  end else begin
                     r_level <= SPURIOUS_LEVEL;
                  end
`ifdef PIC_AUTO_EOI_EN
                  r_spurious <= !w_win_any;
`endif
               end else if (!w_win_any) begin
                  r_int   <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_ACK1: begin
               if (w_fall) begin
                  r_data    <= {vector_base, r_level};
                  r_data_oe <= 1'b1;
                  r_state   <= S_ACK2;
               end
            end
            S_ACK2: begin
               if (w_rise) begin
                  r_data_oe <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign int_out             = r_int;
   assign in_service_register = r_isr;
   assign rotate              = r_rotate;
   assign clear_irr           = r_clear_irr;
   assign data_out            = r_data;
   assign data_oe             = r_data_oe;

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Purpose : self-checking bench for pic_ack_sequencer; vectors go through a scoreboard queue.
// Latency : inputs driven 1 time unit after posedge, outputs checked at the same point.
// Backpressure: n/a - bench paces inta_n directly.
module tb_pic_ack_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] winner;
   logic       inta_n;
   logic [4:0] vector_base;
   logic       eoi_valid;
   logic [2:0] eoi_type;
   logic [2:0] eoi_level;
`ifdef PIC_AUTO_EOI_EN
   logic       aeoi_mode;
   logic       rotate_aeoi;
`endif
   logic       int_out;
   logic [7:0] isr;
   logic [2:0] rotate;
   logic [7:0] clear_irr;
   logic [7:0] data_out;
   logic       data_oe;

   int         n_chk = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];
   logic       prev_oe = 1'b0;

   always #5 clk = ~clk;

   pic_ack_sequencer dut (
      .clk                             (clk),
      .rst_n                           (rst_n),
      .interrupt_from_priorty_resolver (winner),
      .inta_n                          (inta_n),
      .vector_base                     (vector_base),
      .eoi_valid                       (eoi_valid),
      .eoi_type                        (eoi_type),
      .eoi_level                       (eoi_level),
`ifdef PIC_AUTO_EOI_EN
      .aeoi_mode                       (aeoi_mode),
      .rotate_aeoi                     (rotate_aeoi),
`endif
      .int_out                         (int_out),
      .in_service_register             (isr),
      .rotate                          (rotate),
      .clear_irr                       (clear_irr),
      .data_out                        (data_out),
      .data_oe                         (data_oe)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic eoi(input logic [2:0] t, input logic [2:0] l);
      eoi_valid = 1'b1;
      eoi_type  = t;
      eoi_level = l;
      step();
      eoi_valid = 1'b0;
      eoi_type  = 3'b000;
   endtask

   // Full acknowledge of a one-hot winner; optionally issue an S-EOI for the same level on the first INTA fall
   task automatic ack(input logic [7:0] win, input logic [7:0] isr_before, input bit same_eoi);
      logic [2:0] lvl;
      lvl = 3'd0;
      for (int i = 0; i < 8; i++) if (win[i]) lvl = 3'(i);
      winner = win;
      step();
      check("int_on", int_out, 1);
      inta_n = 1'b0;
      if (same_eoi) begin
         eoi_valid = 1'b1;
         eoi_type  = 3'b011;
         eoi_level = lvl;
      end
      step();
      eoi_valid = 1'b0;
      eoi_type  = 3'b000;
      check("isr_set", isr, isr_before | win);
      check("clr_irr", clear_irr, win);
      check("int_off", int_out, 0);
      winner = 8'h00;
      inta_n = 1'b1;
      step();
      check("clr_pulse", clear_irr, 0);
      inta_n = 1'b0;
      exp_q.push_back({vector_base, lvl});
      step();
      check("oe_on", data_oe, 1);
      step();
      check("oe_hold", data_oe, 1);
      inta_n = 1'b1;
      step();
      check("oe_drop", data_oe, 0);
   endtask

   // Scoreboard: every rising data_oe must match the oldest queued vector
   always @(negedge clk) begin
      if (data_oe === 1'b1 && prev_oe !== 1'b1) begin
         if (exp_q.size() == 0) check("vec_unexpected_q", exp_q.size(), 1);
         else check("vec", data_out, exp_q.pop_front());
      end
      prev_oe = data_oe;
   end

   initial begin
      rst_n       = 1'b0;
      winner      = 8'h00;
      inta_n      = 1'b1;
      vector_base = 5'h08;
      eoi_valid   = 1'b0;
      eoi_type    = 3'b000;
      eoi_level   = 3'd0;
`ifdef PIC_AUTO_EOI_EN
      aeoi_mode   = 1'b0;
      rotate_aeoi = 1'b0;
`endif
      step();
      step();
      check("rst_int", int_out, 0);
      check("rst_isr", isr, 0);
      check("rst_rot", rotate, 3'b111);
      check("rst_clr", clear_irr, 0);
      check("rst_dout", data_out, 0);
      check("rst_oe", data_oe, 0);
      rst_n = 1'b1;
      step();

      // Basic acknowledge of IR2 -> vector 0x42
      ack(8'h04, 8'h00, 0);
      check("t1_isr", isr, 8'h04);

      // Non-specific EOI under two rotations
      eoi(3'b011, 3'd2);
      check("t2_sclr", isr, 8'h00);
      ack(8'h02, 8'h00, 0);
      ack(8'h08, 8'h02, 0);
      check("t2_isr0a", isr, 8'h0A);
      eoi(3'b001, 3'd0);
      check("t2_ns_r7", isr, 8'h08);
      ack(8'h02, 8'h08, 0);
      eoi(3'b110, 3'd1);
      check("t2_rot1", rotate, 3'd1);
      check("t2_isr_keep", isr, 8'h0A);
      eoi(3'b001, 3'd0);
      check("t2_ns_r1", isr, 8'h02);

      // Rotate on NS-EOI, set priority, ignored encodings
      eoi(3'b011, 3'd1);
      ack(8'h20, 8'h00, 0);
      eoi(3'b101, 3'd0);
      check("t3_isr", isr, 8'h00);
      check("t3_rot5", rotate, 3'd5);
      eoi(3'b110, 3'd2);
      check("t3_rot2", rotate, 3'd2);
      check("t3_isr_keep", isr, 8'h00);
      eoi(3'b101, 3'd0);
      check("t3_rot_empty", rotate, 3'd2);
      eoi(3'b100, 3'd3);
      check("t3_ign_rot", rotate, 3'd2);
      eoi(3'b111, 3'd6);
      check("t3_rot_s", rotate, 3'd6);
      eoi(3'b110, 3'd7);

      // EOI of the same level in the set cycle: set wins
      ack(8'h10, 8'h00, 1);
      check("same_cyc_isr", isr, 8'h10);
      eoi(3'b011, 3'd4);
      check("same_cyc_clr", isr, 8'h00);

      // Spurious: winner gone on the first INTA fall
      winner = 8'h10;
      step();
      check("sp_int", int_out, 1);
      winner = 8'h00;
      inta_n = 1'b0;
      step();
      check("sp_isr", isr, 8'h00);
      check("sp_clr", clear_irr, 8'h00);
      check("sp_int_off", int_out, 0);
      inta_n = 1'b1;
      step();
      inta_n = 1'b0;
      exp_q.push_back({vector_base, 3'b111});
      step();
      check("sp_oe", data_oe, 1);
      inta_n = 1'b1;
      step();
      check("sp_oe_drop", data_oe, 0);

      // Winner withdrawn before any INTA: INT drops
      winner = 8'h10;
      step();
      check("wd_int", int_out, 1);
      winner = 8'h00;
      step();
      check("wd_int_off", int_out, 0);

      // Reset in ACK1 with ISR=01
      eoi(3'b110, 3'd3);
      winner = 8'h01;
      step();
      inta_n = 1'b0;
      step();
      check("r5_isr", isr, 8'h01);
      winner = 8'h00;
      inta_n = 1'b1;
      step();
      rst_n = 1'b0;
      step();
      check("r5_int", int_out, 0);
      check("r5_isr0", isr, 0);
      check("r5_rot", rotate, 3'b111);
      check("r5_clr", clear_irr, 0);
      check("r5_dout", data_out, 0);
      check("r5_oe", data_oe, 0);
      rst_n = 1'b1;
      step();

      // INTA fall in IDLE is ignored
      inta_n = 1'b0;
      step();
      step();
      check("idle_inta_oe", data_oe, 0);
      check("idle_inta_int", int_out, 0);
      inta_n = 1'b1;
      step();

`ifdef PIC_AUTO_EOI_EN
      aeoi_mode   = 1'b1;
      rotate_aeoi = 1'b1;
      ack(8'h08, 8'h00, 0);
      check("aeoi_isr", isr, 8'h00);
      check("aeoi_rot", rotate, 3'd3);
      aeoi_mode   = 1'b0;
      rotate_aeoi = 1'b0;
`endif

      step();
      check("q_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
